// File: rtl/serial_pattern_pkg.sv
// Shared types for the serial pattern transmitter.
//   state_t : transmitter FSM states (IDLE, SHIFT, GAP)
//   RUN_SAT : saturation value of the run-length counter
package serial_pattern_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [1:0] RUN_SAT = 2'd3;

endpackage

// File: rtl/serial_pattern_tx_if.sv
// Frame handshake + serial line bundle for serial_pattern_tx.
//   in_valid/in_ready/in_data/in_len : frame offer handshake
//   ser_out/ser_active               : serial line and payload qualifier
//   frame_done                       : pulse in the last gap cycle
//   match_pred                       : predicted "second consecutive 1" detector output
// master = frame source / line observer, slave = transmitter.
interface serial_pattern_tx_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = $clog2(WIDTH+1)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [LEN_W-1:0] in_len;
  logic             ser_out;
  logic             ser_active;
  logic             frame_done;
  logic             match_pred;

  modport master (
    output in_valid, in_data, in_len,
    input  in_ready, ser_out, ser_active, frame_done, match_pred
  );

  modport slave (
    input  in_valid, in_data, in_len,
    output in_ready, ser_out, ser_active, frame_done, match_pred
  );
endinterface

// File: rtl/run_length_predictor.sv
// Predicts the output of a downstream "second consecutive 1" detector
// watching a serial line.
//   clk, rst_n : clock, async active-low reset
//   ser_out    : observed serial line
//   match_pred : high exactly one cycle after the second 1 of a run
module run_length_predictor
  import serial_pattern_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic ser_out,
  output logic match_pred
);

  logic [1:0] run_q, run_d;

  // Saturate so runs longer than two never wrap back to the match value.
  always_comb begin
    run_d = '0;
    if (ser_out) run_d = (run_q == RUN_SAT) ? RUN_SAT : run_q + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= '0;
    else        run_q <= run_d;
  end

  assign match_pred = (run_q == 2'd2);

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: accepts a frame over valid/ready, shifts
// in_len bits out MSB-first, then holds the line low for GAP cycles.
//   clk, rst_n : clock, async active-low reset
//   bus        : serial_pattern_tx_if slave (handshake, serial line,
//                frame_done pulse, match_pred prediction)
// Parameters: WIDTH max frame bits, LEN_W in_len width, GAP (1..255).
module serial_pattern_tx
  import serial_pattern_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN_W = $clog2(WIDTH+1),
  parameter int GAP   = 2
)(
  input  logic                clk,
  input  logic                rst_n,
  serial_pattern_tx_if.slave  bus
);

  // The GAP parameter shadows the GAP state literal inside this module,
  // so the state is always referenced through the package scope.
  localparam state_t           ST_GAP   = serial_pattern_pkg::GAP;
  localparam logic [LEN_W-1:0] WIDTH_L  = LEN_W'(WIDTH);
  localparam logic [7:0]       GAP_LAST = 8'(GAP - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [7:0]       gcnt_q, gcnt_d;
  logic [LEN_W-1:0] len_c;

  assign len_c = (bus.in_len > WIDTH_L) ? WIDTH_L : bus.in_len;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          // Left-align the payload so bit len-1 leaves first.
          sr_d    = bus.in_data << (WIDTH_L - len_c);
          cnt_d   = len_c;
          gcnt_d  = GAP_LAST;
          state_d = (len_c == '0) ? ST_GAP : SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = sr_q << 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == LEN_W'(1)) begin
          state_d = ST_GAP;
          gcnt_d  = GAP_LAST;
        end
      end
      ST_GAP: begin
        // gcnt counts down to 0; the zero cycle is the last gap cycle.
        if (gcnt_q == '0) state_d = IDLE;
        else              gcnt_d  = gcnt_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
    end
  end

  // All outputs decode registered state only.
  assign bus.in_ready   = (state_q == IDLE);
  assign bus.ser_active = (state_q == SHIFT);
  assign bus.ser_out    = (state_q == SHIFT) & sr_q[WIDTH-1];
  assign bus.frame_done = (state_q == ST_GAP) && (gcnt_q == '0);

  run_length_predictor u_pred (
    .clk        (clk),
    .rst_n      (rst_n),
    .ser_out    (bus.ser_out),
    .match_pred (bus.match_pred)
  );

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx with an expected-trace scoreboard.
module tb_serial_pattern_tx;
  localparam int WIDTH = 8;
  localparam int LEN_W = 4;
  localparam int GAP   = 2;

  typedef struct packed {
    logic so, act, done, mp, rdy;
  } exp_t;

  logic clk, rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  serial_pattern_tx_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

  serial_pattern_tx #(.WIDTH(WIDTH), .LEN_W(LEN_W), .GAP(GAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer a frame in the current (idle) cycle T and check every cycle up to
  // the first idle cycle afterwards, T+len+GAP+1.
  task automatic send_frame(input string name, input logic [7:0] data, input int len_in);
    int   len, n;
    bit   s [0:31];
    exp_t e;
    len = (len_in > WIDTH) ? WIDTH : len_in;
    n   = len + GAP + 1;
    for (int k = 0; k < 32; k++) s[k] = 1'b0;
    for (int k = 1; k <= len; k++) s[k] = data[len-k];
    for (int k = 1; k <= n; k++) begin
      e.so   = s[k];
      e.act  = (k <= len);
      e.done = (k == len + GAP);
      e.rdy  = (k == n);
      // Detector fires one cycle after a 1 that follows a 1 which itself
      // did not follow a 1.
      e.mp   = (k >= 3) && s[k-1] && s[k-2] && !s[k-3];
      q.push_back(e);
    end
    chk({name, ".accept_rdy"}, bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_len   = LEN_W'(len_in);
    tick();
    bus.in_valid = 1'b0;
    for (int k = 1; k <= n; k++) begin
      e = q.pop_front();
      chk($sformatf("%s.ser_out@T+%0d", name, k),    bus.ser_out,    e.so);
      chk($sformatf("%s.ser_active@T+%0d", name, k), bus.ser_active, e.act);
      chk($sformatf("%s.frame_done@T+%0d", name, k), bus.frame_done, e.done);
      chk($sformatf("%s.match_pred@T+%0d", name, k), bus.match_pred, e.mp);
      chk($sformatf("%s.in_ready@T+%0d", name, k),   bus.in_ready,   e.rdy);
      if (k < n) tick();
    end
  endtask

  initial begin
    int acc[$];
    int waited;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_len   = '0;

    // Reset held 3 cycles; in_ready reads 1 but nothing is captured.
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst.in_ready", bus.in_ready, 1'b1);
      chk("rst.ser_out", bus.ser_out, 1'b0);
      chk("rst.ser_active", bus.ser_active, 1'b0);
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("idle.in_ready", bus.in_ready, 1'b1);
    chk("idle.ser_out", bus.ser_out, 1'b0);
    chk("idle.ser_active", bus.ser_active, 1'b0);
    chk("idle.frame_done", bus.frame_done, 1'b0);
    chk("idle.match_pred", bus.match_pred, 1'b0);

    send_frame("f110", 8'b0000_0110, 3);   // bits 1,1,0
    send_frame("f011", 8'b0000_0011, 3);   // ends in 1,1: match in first gap cycle
    send_frame("fFF",  8'hFF, 8);          // long run: match once only
    send_frame("len0", 8'hFF, 0);          // no payload
    send_frame("clamp", 8'hA5, 12);        // clamps to 8 bits
    send_frame("len1", 8'h01, 1);          // single payload cycle
    send_frame("f1101", 8'b0000_1101, 4);

    // Back-to-back with in_valid held: acceptance every len+GAP+1 cycles.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h05;
    bus.in_len   = LEN_W'(3);
    for (int c = 0; c < 40; c++) begin
      if (bus.in_ready) acc.push_back(c);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("b2b.count_ge3", (acc.size() >= 3), 1'b1);
    if (acc.size() >= 3) begin
      chk("b2b.space1", acc[1] - acc[0], 3 + GAP + 1);
      chk("b2b.space2", acc[2] - acc[1], 3 + GAP + 1);
    end
    waited = 0;
    while (!bus.in_ready && waited < 20) begin
      tick();
      waited++;
    end
    chk("b2b.drain_ready", bus.in_ready, 1'b1);

    // Reset mid-frame at T+2 of an all-ones 8-bit frame.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    bus.in_len   = LEN_W'(8);
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("abort.pre_ser_out", bus.ser_out, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort.ser_out_async", bus.ser_out, 1'b0);
    chk("abort.ser_active_async", bus.ser_active, 1'b0);
    chk("abort.match_pred_async", bus.match_pred, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("abort.rst_frame_done", bus.frame_done, 1'b0);
      chk("abort.rst_in_ready", bus.in_ready, 1'b1);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("abort.post_ser_active", bus.ser_active, 1'b0);
      chk("abort.post_frame_done", bus.frame_done, 1'b0);
      chk("abort.post_in_ready", bus.in_ready, 1'b1);
    end

    // Frame after abort still works normally.
    send_frame("post", 8'b0000_0110, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
